// File: rtl/sdio_bus_pkg.sv
// Shared types and constants for the SDIO local-bus arbiter.
// Includes the state encoding, the default address width and the read data returned on timeout.
package sdio_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT     = 2'd1,
        BUSY_WR = 2'd2,
        BUSY_RD = 2'd3
    } arb_st_e;

    localparam int AW_DEF = 16;

    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

endpackage

// File: rtl/sdio_bus_rr_pick.sv
// Two-request round-robin picker.
// When both requests are high, prio selects the winner; otherwise the single requester wins.
module sdio_bus_rr_pick (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt,
    output logic       valid
);

    assign valid = |req;
    assign gnt   = (req == 2'b11) ? prio : req[1];

endmodule

// File: rtl/sdio_bus_arb.sv
// Two-master, one-slave arbiter for the byte-wide local bus, with a round-robin grant held until the transaction completes.
// The optional BUSY watchdog is compiled in with SDIO_BUS_ARB_TIMEOUT_EN.
module sdio_bus_arb
    import sdio_bus_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int TO_W = 8
) (
    input  logic          bus_clk,
    input  logic          rstn,
    input  logic          arb_rst,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_rd,
    input  logic          m0_wr,
    input  logic          m1_rd,
    input  logic          m1_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [7:0]    m0_wdata,
    input  logic [7:0]    m1_wdata,
    output logic          m0_ready,
    output logic          m1_ready,
    output logic          m0_rdata_ready,
    output logic          m1_rdata_ready,
    output logic [7:0]    m_rdata,
    input  logic          s_ready,
    input  logic          s_rdata_ready,
    input  logic [7:0]    s_rdata,
    output logic [AW-1:0] s_addr,
    output logic [7:0]    s_wdata,
    output logic          s_rd,
    output logic          s_wr,
    output logic          owner,
    output logic [2:0]    arb_state,
    output logic          timeout
);

    arb_st_e st_q, st_d;
    logic    owner_q, owner_d;
    logic    prio_q, prio_d;

    logic          pick_gnt;
    logic          pick_valid;
    logic          own_req;
    logic          own_rd;
    logic          own_wr;
    logic [AW-1:0] own_addr;
    logic [7:0]    own_wdata;
    logic          rdy;
    logic          rdv;
    logic          to_hit;
    logic          to_pulse;
    logic          busy;

    sdio_bus_rr_pick u_pick (
        .req   ({m1_req, m0_req}),
        .prio  (prio_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    assign own_req   = owner_q ? m1_req   : m0_req;
    assign own_rd    = owner_q ? m1_rd    : m0_rd;
    assign own_wr    = owner_q ? m1_wr    : m0_wr;
    assign own_addr  = owner_q ? m1_addr  : m0_addr;
    assign own_wdata = owner_q ? m1_wdata : m0_wdata;
    assign busy      = (st_q == BUSY_WR) || (st_q == BUSY_RD);

`ifdef SDIO_BUS_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_q, to_d;

    // The counter is zero on the first BUSY cycle because it is held clear outside BUSY.
    assign to_d   = (busy && !arb_rst) ? to_q + TO_W'(1) : '0;
    assign to_hit = busy && (&to_q) && !arb_rst;

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign to_hit = |{TO_W{1'b0}};
`endif

    always_comb begin
        st_d     = st_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        rdy      = 1'b0;
        rdv      = 1'b0;
        s_rd     = 1'b0;
        s_wr     = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        m_rdata  = '0;
        to_pulse = 1'b0;

        case (st_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_gnt;
                    st_d    = GNT;
                end
            end
            GNT: begin
                s_addr  = own_addr;
                s_wdata = own_wdata;
                rdy     = s_ready;
                s_rd    = own_rd;
                s_wr    = own_wr && !own_rd;
                if (own_rd) begin
                    st_d = BUSY_RD;
                end else if (own_wr) begin
                    st_d = BUSY_WR;
                end else if (!own_req) begin
                    st_d = IDLE;
                end
            end
            BUSY_WR: begin
                s_addr  = own_addr;
                s_wdata = own_wdata;
                rdy     = s_ready;
                if (s_ready) begin
                    st_d   = IDLE;
                    prio_d = ~owner_q;
                end else if (to_hit) begin
                    rdy      = 1'b1;
                    to_pulse = 1'b1;
                    st_d     = IDLE;
                    prio_d   = ~owner_q;
                end
            end
            BUSY_RD: begin
                s_addr  = own_addr;
                rdv     = s_rdata_ready;
                m_rdata = s_rdata;
                if (s_rdata_ready) begin
                    st_d   = IDLE;
                    prio_d = ~owner_q;
                end else if (to_hit) begin
                    rdv      = 1'b1;
                    m_rdata  = TIMEOUT_RDATA;
                    to_pulse = 1'b1;
                    st_d     = IDLE;
                    prio_d   = ~owner_q;
                end
            end
            default: st_d = IDLE;
        endcase

        // A soft clear abandons any transaction and suppresses its completion strobes.
        if (arb_rst) begin
            st_d     = IDLE;
            owner_d  = 1'b0;
            prio_d   = 1'b0;
            rdy      = 1'b0;
            rdv      = 1'b0;
            s_rd     = 1'b0;
            s_wr     = 1'b0;
            s_addr   = '0;
            s_wdata  = '0;
            m_rdata  = '0;
            to_pulse = 1'b0;
        end
    end

    always_ff @(posedge bus_clk or negedge rstn) begin
        if (!rstn) begin
            st_q    <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    assign m0_ready       = rdy && !owner_q;
    assign m1_ready       = rdy && owner_q;
    assign m0_rdata_ready = rdv && !owner_q;
    assign m1_rdata_ready = rdv && owner_q;
    assign owner          = owner_q;
    assign arb_state      = {owner_q, st_q};
    assign timeout        = to_pulse;

endmodule

// File: tb/tb_sdio_bus_arb.sv
// Directed and randomized checks of the two-master bus arbiter against a transaction-level model.
// The watchdog steps run only when SDIO_BUS_ARB_TIMEOUT_EN is defined.
module tb_sdio_bus_arb;

    localparam int AW   = 16;
    localparam int TO_W = 4;

    logic          bus_clk = 1'b0;
    logic          rstn;
    logic          arb_rst;
    logic          m0_req, m1_req;
    logic          m0_rd, m0_wr, m1_rd, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [7:0]    m0_wdata, m1_wdata;
    logic          m0_ready, m1_ready;
    logic          m0_rdata_ready, m1_rdata_ready;
    logic [7:0]    m_rdata;
    logic          s_ready, s_rdata_ready;
    logic [7:0]    s_rdata;
    logic [AW-1:0] s_addr;
    logic [7:0]    s_wdata;
    logic          s_rd, s_wr;
    logic          owner;
    logic [2:0]    arb_state;
    logic          timeout;

    int checks   = 0;
    int failures = 0;

    sdio_bus_arb #(.AW(AW), .TO_W(TO_W)) dut (
        .bus_clk        (bus_clk),
        .rstn           (rstn),
        .arb_rst        (arb_rst),
        .m0_req         (m0_req),
        .m1_req         (m1_req),
        .m0_rd          (m0_rd),
        .m0_wr          (m0_wr),
        .m1_rd          (m1_rd),
        .m1_wr          (m1_wr),
        .m0_addr        (m0_addr),
        .m1_addr        (m1_addr),
        .m0_wdata       (m0_wdata),
        .m1_wdata       (m1_wdata),
        .m0_ready       (m0_ready),
        .m1_ready       (m1_ready),
        .m0_rdata_ready (m0_rdata_ready),
        .m1_rdata_ready (m1_rdata_ready),
        .m_rdata        (m_rdata),
        .s_ready        (s_ready),
        .s_rdata_ready  (s_rdata_ready),
        .s_rdata        (s_rdata),
        .s_addr         (s_addr),
        .s_wdata        (s_wdata),
        .s_rd           (s_rd),
        .s_wr           (s_wr),
        .owner          (owner),
        .arb_state      (arb_state),
        .timeout        (timeout)
    );

    always #5 bus_clk = ~bus_clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        arb_rst = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        s_ready = 1'b1; s_rdata_ready = 1'b0; s_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge bus_clk);
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge bus_clk);
        rstn = 1'b1;
    endtask

    logic [1:0]    r;
    logic          exp_prio;
    logic          exp_owner;
    logic          c_rd, c_wr, n_rd, n_wr;
    logic [AW-1:0] a0, a1;
    logic [7:0]    d0, d1, rd_data;
    int            w;

    initial begin
        rstn = 1'b0;
        clear_inputs();
        // Reset state with slave inputs active: nothing may leak through.
        s_rdata_ready = 1'b1; s_rdata = 8'h77; m0_req = 1'b1; m0_rd = 1'b1;
        repeat (2) @(negedge bus_clk);
        #1;
        chk("rst_state", 32'(arb_state), 32'h0);
        chk("rst_ready", 32'({m0_ready, m1_ready, m0_rdata_ready, m1_rdata_ready}), 32'h0);
        chk("rst_cmd", 32'({s_rd, s_wr, timeout}), 32'h0);
        chk("rst_bus", 32'({s_addr, s_wdata, m_rdata}), 32'h0);
        clear_inputs();
        rstn = 1'b1;

        // Single master write.
        @(negedge bus_clk); m0_req = 1'b1;
        #1 chk("t1_idle", 32'(arb_state), 32'h0);
        @(negedge bus_clk); m0_wr = 1'b1; m0_addr = 16'h0010; m0_wdata = 8'hA5;
        #1;
        chk("t1_gnt", 32'(arb_state), 32'h1);
        chk("t1_s_wr", 32'({s_wr, s_rd}), 32'h2);
        chk("t1_s_addr", 32'(s_addr), 32'h0010);
        chk("t1_s_wdata", 32'(s_wdata), 32'hA5);
        chk("t1_ready", 32'({m0_ready, m1_ready}), 32'h2);
        @(negedge bus_clk); m0_wr = 1'b0; m0_req = 1'b0;
        #1;
        chk("t1_busy_wr", 32'(arb_state), 32'h2);
        chk("t1_wr_done", 32'({m0_ready, s_wr}), 32'h2);
        @(negedge bus_clk);
        #1 chk("t1_release", 32'(arb_state), 32'h0);

        // prio is now 1: contention goes to m1; dropping req in GNT keeps prio.
        @(negedge bus_clk); m0_req = 1'b1; m1_req = 1'b1;
        @(negedge bus_clk);
        #1 chk("t4_gnt_m1", 32'(arb_state), 32'h5);
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge bus_clk);
        #1 chk("t4_drop_idle", 32'(arb_state), 32'h4);
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge bus_clk);
        #1 chk("t4_prio_kept", 32'(arb_state), 32'h5);
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge bus_clk);
        #1 chk("t4_idle2", 32'(arb_state), 32'h4);

        // Contention from reset, then intrusion from the non-owner during BUSY_RD.
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge bus_clk);
        #1 chk("t2_gnt_m0", 32'(arb_state), 32'h1);
        m0_rd = 1'b1; m0_addr = 16'h0020;
        #1;
        chk("t2_s_rd", 32'({s_rd, s_wr}), 32'h2);
        chk("t2_s_addr", 32'(s_addr), 32'h0020);
        chk("t2_m1_ready", 32'(m1_ready), 32'h0);
        @(negedge bus_clk); m0_rd = 1'b0; m1_rd = 1'b1;
        #1;
        chk("t3_busy_rd", 32'(arb_state), 32'h3);
        chk("t3_s_rd_blocked", 32'({s_rd, s_wr}), 32'h0);
        chk("t3_m1_ready", 32'({m1_ready, m1_rdata_ready}), 32'h0);
        @(negedge bus_clk); m1_rd = 1'b0; s_rdata_ready = 1'b1; s_rdata = 8'h3C;
        #1;
        chk("t2_rdata_ready", 32'({m0_rdata_ready, m1_rdata_ready}), 32'h2);
        chk("t2_rdata", 32'(m_rdata), 32'h3C);
        @(negedge bus_clk); s_rdata_ready = 1'b0;
        #1 chk("t2_idle", 32'(arb_state), 32'h0);
        @(negedge bus_clk);
        #1 chk("t2_gnt_m1_next", 32'(arb_state), 32'h5);
        m1_rd = 1'b1; m1_wr = 1'b1; m1_addr = 16'hBEEF;
        #1;
        chk("rdwr_rd_wins", 32'({s_rd, s_wr}), 32'h2);
        chk("rdwr_addr", 32'(s_addr), 32'hBEEF);
        @(negedge bus_clk); m1_rd = 1'b0; m1_wr = 1'b0;
        #1 chk("rdwr_busy_rd", 32'(arb_state), 32'h7);
        @(negedge bus_clk); s_rdata_ready = 1'b1; s_rdata = 8'h5A; m0_req = 1'b0; m1_req = 1'b0;
        #1;
        chk("m1_rdata_ready", 32'({m0_rdata_ready, m1_rdata_ready}), 32'h1);
        chk("m1_rdata", 32'(m_rdata), 32'h5A);
        @(negedge bus_clk); s_rdata_ready = 1'b0;
        #1 chk("m1_idle", 32'(arb_state), 32'h4);

        // Soft clear in the middle of a read.
        @(negedge bus_clk); m0_req = 1'b1;
        @(negedge bus_clk); m0_rd = 1'b1; m0_addr = 16'h0042;
        #1 chk("t5_gnt", 32'(arb_state), 32'h5 & 32'h1);
        @(negedge bus_clk); m0_rd = 1'b0; m0_req = 1'b0;
        #1 chk("t5_busy_rd", 32'(arb_state), 32'h3);
        @(negedge bus_clk); arb_rst = 1'b1; s_rdata_ready = 1'b1; s_rdata = 8'h99;
        #1 chk("t5_no_fwd", 32'({m0_rdata_ready, m1_rdata_ready, m_rdata}), 32'h0);
        @(negedge bus_clk); arb_rst = 1'b0;
        #1;
        chk("t5_idle", 32'(arb_state), 32'h0);
        chk("t5_late_strobe", 32'({m0_rdata_ready, m1_rdata_ready}), 32'h0);
        @(negedge bus_clk); s_rdata_ready = 1'b0;

`ifdef SDIO_BUS_ARB_TIMEOUT_EN
        // Read that the slave never answers.
        @(negedge bus_clk); m0_req = 1'b1;
        @(negedge bus_clk); m0_rd = 1'b1;
        #1 chk("t6_gnt", 32'(arb_state), 32'h1);
        @(negedge bus_clk); m0_rd = 1'b0; m0_req = 1'b0;
        for (int k = 0; k < (1 << TO_W) - 1; k++) begin
            if (k != 0) @(negedge bus_clk);
            #1;
            chk("t6_waiting", 32'({arb_state, timeout, m0_rdata_ready}), 32'({3'd3, 2'b00}));
        end
        @(negedge bus_clk);
        #1;
        chk("t6_timeout", 32'({timeout, m0_rdata_ready, m1_rdata_ready}), 32'h6);
        chk("t6_rdata_ff", 32'(m_rdata), 32'hFF);
        @(negedge bus_clk);
        #1 chk("t6_idle", 32'({arb_state, timeout}), 32'h0);
`endif

        // Random transactions against the transaction-level model.
        do_reset();
        exp_prio = 1'b0;
        for (int t = 0; t < 60; t++) begin
            r = 2'($urandom_range(1, 3));
            @(negedge bus_clk); m0_req = r[0]; m1_req = r[1];
            #1 chk("rnd_idle", 32'(arb_state[1:0]), 32'h0);
            exp_owner = (r == 2'b11) ? exp_prio : r[1];
            c_rd = 1'($urandom_range(0, 1)); c_wr = 1'($urandom_range(0, 1));
            n_rd = 1'($urandom_range(0, 1)); n_wr = 1'($urandom_range(0, 1));
            a0 = AW'($urandom); a1 = AW'($urandom);
            d0 = 8'($urandom); d1 = 8'($urandom);
            @(negedge bus_clk);
            m0_addr = a0; m1_addr = a1; m0_wdata = d0; m1_wdata = d1; s_ready = 1'b1;
            m0_rd = exp_owner ? n_rd : c_rd; m0_wr = exp_owner ? n_wr : c_wr;
            m1_rd = exp_owner ? c_rd : n_rd; m1_wr = exp_owner ? c_wr : n_wr;
            #1;
            chk("rnd_gnt", 32'(arb_state), 32'({exp_owner, 2'b01}));
            chk("rnd_owner", 32'(owner), 32'(exp_owner));
            chk("rnd_s_addr", 32'(s_addr), 32'(exp_owner ? a1 : a0));
            chk("rnd_s_wdata", 32'(s_wdata), 32'(exp_owner ? d1 : d0));
            chk("rnd_s_cmd", 32'({s_rd, s_wr}), 32'({c_rd, c_wr && !c_rd}));
            chk("rnd_ready", 32'({m1_ready, m0_ready}), 32'(exp_owner ? 2'b10 : 2'b01));
            if (!c_rd && !c_wr) begin
                @(negedge bus_clk);
                m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
                m0_req = 1'b0; m1_req = 1'b0;
                @(negedge bus_clk);
                #1 chk("rnd_drop_idle", 32'(arb_state), 32'({exp_owner, 2'b00}));
            end else begin
                @(negedge bus_clk);
                m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0; s_ready = 1'b0;
                #1 chk("rnd_busy", 32'(arb_state), 32'({exp_owner, c_rd ? 2'b11 : 2'b10}));
                w = $urandom_range(0, 5);
                for (int k = 0; k < w; k++) begin
                    @(negedge bus_clk);
                    #1 chk("rnd_wait", 32'({m0_ready, m1_ready, m0_rdata_ready, m1_rdata_ready, s_rd, s_wr}), 32'h0);
                end
                @(negedge bus_clk);
                rd_data = 8'($urandom);
                if (c_rd) begin
                    s_rdata_ready = 1'b1; s_rdata = rd_data;
                end else begin
                    s_ready = 1'b1;
                end
                m0_req = 1'b0; m1_req = 1'b0;
                #1;
                if (c_rd) begin
                    chk("rnd_rd_strobe", 32'({m1_rdata_ready, m0_rdata_ready}), 32'(exp_owner ? 2'b10 : 2'b01));
                    chk("rnd_rd_data", 32'(m_rdata), 32'(rd_data));
                end else begin
                    chk("rnd_wr_ready", 32'({m1_ready, m0_ready}), 32'(exp_owner ? 2'b10 : 2'b01));
                end
                @(negedge bus_clk); s_rdata_ready = 1'b0; s_ready = 1'b1;
                #1 chk("rnd_done_idle", 32'(arb_state), 32'({exp_owner, 2'b00}));
                exp_prio = ~exp_owner;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
